pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/mips_pkg.sv | 14 +
 rtl/pc_target_mux.sv | 33 +++
 rtl/pc_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end: word width,
// default reset vector and the fetch sequencer state enumeration.
package mips_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_target_mux.sv
// Redirect target selection (jr > j > branch) with word alignment and
// detection of a misaligned raw target.
module pc_target_mux
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] redir_pc4,
  input  logic              br_valid,
  input  logic [WORD_W-1:0] br_offset,
  input  logic              j_valid,
  input  logic [25:0]       j_index,
  input  logic              jr_valid,
  input  logic [WORD_W-1:0] jr_target,
  output logic              redirect,
  output logic [WORD_W-1:0] target,
  output logic              misaligned
);

  logic [WORD_W-1:0] raw_target;

  always_comb begin
    raw_target = redir_pc4 + br_offset;
    if (jr_valid) begin
      raw_target = jr_target;
    end else if (j_valid) begin
      raw_target = {redir_pc4[31:28], j_index, 2'b00};
    end
  end

  assign redirect   = jr_valid | j_valid | br_valid;
  assign target     = {raw_target[WORD_W-1:2], 2'b00};
  assign misaligned = redirect & (raw_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: issues fetches from the PC, hands words to
// decode one at a time and absorbs branch/jump redirects in any state.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] redir_pc4,
  input  logic        br_valid,
  input  logic [31:0] br_offset,
  input  logic        j_valid,
  input  logic [25:0] j_index,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  input  logic        if_ready,
  output logic        misalign
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic        misalign_q, misalign_d;

  logic        redirect;
  logic [31:0] target;
  logic        target_misaligned;

  pc_target_mux u_target_mux (
    .redir_pc4  (redir_pc4),
    .br_valid   (br_valid),
    .br_offset  (br_offset),
    .j_valid    (j_valid),
    .j_index    (j_index),
    .jr_valid   (jr_valid),
    .jr_target  (jr_target),
    .redirect   (redirect),
    .target     (target),
    .misaligned (target_misaligned)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc4_d   = if_pc4_q;
    misalign_d = target_misaligned;

    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d = target;
          end else begin
            if_instr_d = imem_rdata;
            if_pc4_d   = pc_q + 32'd4;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
            state_d    = ST_HOLD;
          end
        end else if (redirect) begin
          // Request already in flight: keep the address, retire it in FLUSH.
          pend_d  = target;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (redirect) begin
          pend_d = target;
        end
        if (imem_ack) begin
          pc_d    = redirect ? target : pend_q;
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          pc_d       = target;
          state_d    = ST_FETCH;
        end else if (if_ready && !stall) begin
          if_valid_d = 1'b0;
          state_d    = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      pend_q     <= 32'd0;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'd0;
      if_pc4_q   <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc4_q   <= if_pc4_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_FLUSH);
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc4    = if_pc4_q;
  assign misalign  = misalign_q;

endmodule
